dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the added access latency in cycles (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request presented by the pipeline memory stage.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_op_sel  input  3  funct3 size code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  requester consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 SHALL have port rsp_err  output  1  access faulted; no state changed.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE, with req_ready=1 only in IDLE.
REQ-016 IDLE: when req_valid=1, SHALL latch we/addr/wdata/op_sel, load the wait counter with WAIT_CYCLES, and go to BUSY.
REQ-017 BUSY: SHALL decrement the counter each cycle; when the counter is 0, SHALL perform the access and go to RESP.
REQ-018 Timing: rsp_valid SHALL rise exactly WAIT_CYCLES+2 cycles after the accepting edge; WAIT_CYCLES=0 SHALL give 2 cycles.
REQ-019 RESP: rsp_valid=1, and rsp_rdata/rsp_err SHALL be held stable until a cycle with rsp_ready=1; that edge SHALL return to IDLE.
REQ-020 Overlap: SHALL NOT accept a new request in the cycle a response is consumed.
- Maximum throughput: one access per WAIT_CYCLES+3 cycles.
REQ-021 Store commit: storage SHALL be written at the BUSY->RESP edge, using byte lanes selected by addr[1:0] (byte) or addr[1] (half); other lanes are unchanged.
REQ-022 Store response: rsp_rdata SHALL be 0.
REQ-023 Loads: SHALL extract the selected lane(s); codes 000/001 sign-extend, codes 100/101 zero-extend.
REQ-024 Out of range: word index >= DEPTH_WORDS, or an illegal op_sel (011, 110, 111), SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-025 Bus hold: req_* inputs SHALL be ignored outside IDLE.
- rsp_ready SHALL be ignored outside RESP.

Reset
REQ-026 While rst=0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 1 after reset is released.
REQ-027 Reset mid-access SHALL abort it: a store not yet committed SHALL NOT be written, and any pending response SHALL be discarded.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_ERR_EN, when defined: half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL complete with rsp_err=1, no write, and rsp_rdata=0.
REQ-030 Macro DMEM_MISALIGN_ERR_EN, when undefined: SHALL force the misaligned low address bits to 0 and perform the access normally.

Structure
REQ-031 Shared package core_pkg SHALL hold the op_sel encodings and the FSM state enum (IDLE, BUSY, RESP).
REQ-032 SHALL contain one sub-module, dmem_lane_align, which is combinational and handles load extraction/extension and store byte-enable/data replication.

Verification
REQ-033 Reset/store/load word: WAIT_CYCLES=2, SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF; each rsp_valid 4 cycles after acceptance.
REQ-034 Sign extension: memory word 0x000080F0 @0x20 -> LB @0x20 = 0xFFFFFFF0, LBU @0x20 = 0x000000F0, LH @0x20 = 0xFFFF80F0, LHU @0x20 = 0x000080F0.
REQ-035 Byte store merge: SB 0xAA @0x23 over 0x11223344 -> LW @0x20 = 0xAA223344.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, data stable, req_ready stays 0; consumed on cycle 6.
REQ-037 Errors: LW @ DEPTH_WORDS*4 -> rsp_err=1, rsp_rdata=0.
- LW @0x22: rsp_err=1 with DEPTH_WORDS=1024 and the macro defined; without the macro, returns word @0x20.
REQ-038 Reset abort: rst asserted during BUSY of SW 0x12345678 @0x30 (prior value 0) -> after release LW @0x30 = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the data-memory path: funct3 size codes and the responder FSM states.
package core_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load lane extraction/extension, store byte enables and data replication.
module dmem_lane_align
  import core_pkg::*;
(
  input  logic [2:0]  op_sel_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: op_sel[1:0] carries the access size.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (op_sel_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the lane, then sign- or zero-extend.
  always_comb begin
    byte_s = 8'h00;
    case (lo_i)
      2'd0:    byte_s = rd_word_i[7:0];
      2'd1:    byte_s = rd_word_i[15:8];
      2'd2:    byte_s = rd_word_i[23:16];
      2'd3:    byte_s = rd_word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (op_sel_i)
      OP_LB:   rdata_o = {{24{byte_s[7]}}, byte_s};
      OP_LH:   rdata_o = {{16{half_s[15]}}, half_s};
      OP_LW:   rdata_o = rd_word_i;
      OP_LBU:  rdata_o = {24'h00_0000, byte_s};
      OP_LHU:  rdata_o = {16'h0000, half_s};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: one outstanding load/store with WAIT_CYCLES of added latency.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors.
module dmem_responder
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_op_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [AW-1:0] idx_s;
  logic [1:0]    lo_s;
  logic          misalign_s;
  logic          fault_s;
  logic          access_s;
  logic          mem_we_s;
  logic [3:0]    be_s;
  logic [31:0]   wrep_s;
  logic [31:0]   load_s;
  logic [31:0]   rd_word_s;

  // Address decode and fault classification of the latched request.
  always_comb begin
    idx_s     = addr_q[AW+1:2];
    rd_word_s = mem_q[idx_s];
`ifdef DMEM_MISALIGN_ERR_EN
    lo_s       = addr_q[1:0];
    misalign_s = ((op_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((op_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
    case (op_q[1:0])
      2'b01:   lo_s = {addr_q[1], 1'b0};
      2'b10:   lo_s = 2'b00;
      default: lo_s = addr_q[1:0];
    endcase
`endif
    fault_s = misalign_s || !op_legal(op_q) || ({2'b00, addr_q[31:2]} >= DEPTH_L);
  end

  dmem_lane_align u_align (
    .op_sel_i  (op_q),
    .lo_i      (lo_s),
    .wdata_i   (wdata_q),
    .rd_word_i (rd_word_s),
    .be_o      (be_s),
    .wdata_o   (wrep_s),
    .rdata_o   (load_s)
  );

  // State register plus latched request and response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      op_q    <= OP_LW;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the access happens on the edge that leaves BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    access_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          op_d    = req_op_sel;
          cnt_d   = WAIT_L;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          access_s = 1'b1;
          rdata_d  = (we_q || fault_s) ? 32'h0000_0000 : load_s;
          err_d    = fault_s;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = 32'h0000_0000;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    mem_we_s  = access_s && we_q && !fault_s;
  end

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wrep_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus backpressure and reset-abort sequences.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;
  localparam int BOUND = 50;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_op_sel = 3'b010;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_op_sel (req_op_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] op,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.op = op;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Present a request from a negedge and hold it until the accepting posedge.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] op);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) begin
      n_checks++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within %0d cycles", BOUND);
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_op_sel = op;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Latency in cycles counted from the acceptance cycle (first negedge after the accept edge = 1).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < BOUND);
  endtask

  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] op, output logic [31:0] rd, output logic er,
                           output int lat);
    start_req(we, a, d, op);
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic        er;
    int          lat;

    vecs.push_back(mk("sw_deadbeef",  1'b1, 32'h10,   32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0));
    vecs.push_back(mk("lw_deadbeef",  1'b0, 32'h10,   32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk("sw_80f0",      1'b1, 32'h20,   32'h0000_80F0, 3'b010, 32'h0, 1'b0));
    vecs.push_back(mk("lb_sext",      1'b0, 32'h20,   32'h0,         3'b000, 32'hFFFF_FFF0, 1'b0));
    vecs.push_back(mk("lbu_zext",     1'b0, 32'h20,   32'h0,         3'b100, 32'h0000_00F0, 1'b0));
    vecs.push_back(mk("lh_sext",      1'b0, 32'h20,   32'h0,         3'b001, 32'hFFFF_80F0, 1'b0));
    vecs.push_back(mk("lhu_zext",     1'b0, 32'h20,   32'h0,         3'b101, 32'h0000_80F0, 1'b0));
    vecs.push_back(mk("sw_11223344",  1'b1, 32'h20,   32'h1122_3344, 3'b010, 32'h0, 1'b0));
    vecs.push_back(mk("sb_aa_23",     1'b1, 32'h23,   32'h0000_00AA, 3'b000, 32'h0, 1'b0));
    vecs.push_back(mk("lw_merge",     1'b0, 32'h20,   32'h0,         3'b010, 32'hAA22_3344, 1'b0));
    vecs.push_back(mk("lb_lane3",     1'b0, 32'h23,   32'h0,         3'b000, 32'hFFFF_FFAA, 1'b0));
    vecs.push_back(mk("lhu_upper",    1'b0, 32'h22,   32'h0,         3'b101, 32'h0000_AA22, 1'b0));
    vecs.push_back(mk("sh_upper",     1'b1, 32'h12,   32'h1234_BEEF, 3'b001, 32'h0, 1'b0));
    vecs.push_back(mk("lw_sh_merge",  1'b0, 32'h10,   32'h0,         3'b010, 32'hBEEF_BEEF, 1'b0));
    vecs.push_back(mk("lw_oor",       1'b0, DEPTH*4,  32'h0,         3'b010, 32'h0, 1'b1));
    vecs.push_back(mk("sw_oor",       1'b1, DEPTH*4,  32'h5555_5555, 3'b010, 32'h0, 1'b1));
    vecs.push_back(mk("ld_op011",     1'b0, 32'h20,   32'h0,         3'b011, 32'h0, 1'b1));
    vecs.push_back(mk("st_op110",     1'b1, 32'h20,   32'hFFFF_FFFF, 3'b110, 32'h0, 1'b1));
    vecs.push_back(mk("lw_no_write",  1'b0, 32'h20,   32'h0,         3'b010, 32'hAA22_3344, 1'b0));
`ifdef DMEM_MISALIGN_ERR_EN
    vecs.push_back(mk("lw_mis_22",    1'b0, 32'h22,   32'h0,         3'b010, 32'h0, 1'b1));
    vecs.push_back(mk("lh_mis_21",    1'b0, 32'h21,   32'h0,         3'b001, 32'h0, 1'b1));
`else
    vecs.push_back(mk("lw_mis_22",    1'b0, 32'h22,   32'h0,         3'b010, 32'hAA22_3344, 1'b0));
    vecs.push_back(mk("lh_mis_21",    1'b0, 32'h21,   32'h0,         3'b001, 32'h0000_3344, 1'b0));
`endif
    vecs.push_back(mk("sw_zero_30",   1'b1, 32'h30,   32'h0,         3'b010, 32'h0, 1'b0));

    // Reset state, then release.
    @(negedge clk);
    check32("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check32("reset_rsp_rdata", rsp_rdata, 32'h0);
    check32("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check32("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].op, rd, er, lat);
      check32({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check32({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
      check32({vecs[i].name, "_latency"}, 32'(lat), 32'(WAIT + 2));
    end

    // Backpressure: hold rsp_ready low 5 cycles while a conflicting store sits on the bus.
    start_req(1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp(lat);
    check32("bp_latency", 32'(lat), 32'(WAIT + 2));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_op_sel = 3'b010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check32("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check32("bp_rsp_rdata", rsp_rdata, 32'hBEEF_BEEF);
      check32("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check32("consume_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check32("consume_no_overlap", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b0;
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    check32("bus_hold_ignored", rd, 32'hBEEF_BEEF);

    // Reset during BUSY aborts the uncommitted store.
    start_req(1'b1, 32'h30, 32'h1234_5678, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check32("abort_idle", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 32'h30, 32'h0, 3'b010, rd, er, lat);
    check32("abort_no_write", rd, 32'h0);

    // Reset during RESP discards the pending response; storage survives reset.
    start_req(1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp(lat);
    rst = 1'b0;
    #1;
    check32("resp_abort_valid", {31'h0, rsp_valid}, 32'h0);
    check32("resp_abort_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("resp_abort_stays_idle", {31'h0, rsp_valid}, 32'h0);
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    check32("mem_kept_over_reset", rd, 32'hBEEF_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
